// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS-style multiply/divide unit with HI/LO registers.
//   One radix-2 step per cycle: shift-add for MULT/MULTU and restoring
//   shift-subtract for DIV/DIVU. Both operate on operand magnitudes, and the
//   sign is corrected in FINISH. An operation takes N+1 busy cycles. A divide
//   by zero skips RUN and leaves HI/LO untouched.
// Ports:
//   clock, reset      rising-edge clock, async active-low reset
//   start, op, inA/B  request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hi/lo_write,      MTHI/MTLO, honoured only while idle
//   write_data
//   busy, done,       status; done and div_by_zero are one-cycle pulses
//   div_by_zero
//   hi, lo            architectural HI/LO registers
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         hi_write,
  input  logic         lo_write,
  input  logic [N-1:0] write_data,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    up_q, up_d;     // product high half / partial remainder
  logic [N-1:0]    lw_q, lw_d;     // multiplier shifting out / quotient shifting in
  logic [N-1:0]    dv_q, dv_d;     // multiplicand or divisor magnitude
  logic            is_div_q, is_div_d;
  logic            nq_q, nq_d;     // negate product / quotient
  logic            nr_q, nr_d;     // negate remainder (sign of dividend)
  logic            dz_q, dz_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;
  logic [N-1:0]    hi_q, hi_d;
  logic [N-1:0]    lo_q, lo_d;

  // Operand magnitudes; the signed ops are those with op[0]=0.
  logic         a_neg, b_neg;
  logic [N-1:0] a_mag, b_mag;
  assign a_neg = ~op[0] & inA[N-1];
  assign b_neg = ~op[0] & inB[N-1];
  assign a_mag = a_neg ? -inA : inA;
  assign b_mag = b_neg ? -inB : inB;

  // Multiply step: add the multiplicand when the multiplier LSB is set, then
  // shift the {carry, up, lw} concatenation right by one.
  logic [N:0] add_sum;
  assign add_sum = {1'b0, up_q} + (lw_q[0] ? {1'b0, dv_q} : {(N+1){1'b0}});

  // Divide step: shift the next dividend bit into the remainder and trial-subtract.
  // An extra top bit keeps the borrow unambiguous when the shifted value is >= 2^N.
  logic [N+1:0] sub_diff;
  logic         sub_ok;
  assign sub_diff = {1'b0, up_q, lw_q[N-1]} - {2'b00, dv_q};
  assign sub_ok   = ~sub_diff[N+1];

  // Sign correction of the finished magnitudes.
  logic [2*N-1:0] prod_mag, prod_fix;
  logic [N-1:0]   quo_fix, rem_fix;
  assign prod_mag = {up_q, lw_q};
  assign prod_fix = nq_q ? -prod_mag : prod_mag;
  assign quo_fix  = nq_q ? -lw_q : lw_q;
  assign rem_fix  = nr_q ? -up_q : up_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    up_d     = up_q;
    lw_d     = lw_q;
    dv_d     = dv_q;
    is_div_d = is_div_q;
    nq_d     = nq_q;
    nr_d     = nr_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (hi_write) hi_d = write_data;
        if (lo_write) lo_d = write_data;
        if (start) begin
          cnt_d    = '0;
          up_d     = '0;
          lw_d     = a_mag;
          dv_d     = b_mag;
          is_div_d = op[1];
          nq_d     = a_neg ^ b_neg;
          nr_d     = a_neg;
          dz_d     = op[1] && (inB == '0);
          state_d  = (op[1] && (inB == '0)) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          up_d = sub_ok ? sub_diff[N-1:0] : {up_q[N-2:0], lw_q[N-1]};
          lw_d = {lw_q[N-2:0], sub_ok};
        end else begin
          up_d = add_sum[N:1];
          lw_d = {add_sum[0], lw_q[N-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        dbz_d   = dz_q;
        if (!dz_q) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*N-1:N];
            lo_d = prod_fix[N-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      up_q     <= '0;
      lw_q     <= '0;
      dv_q     <= '0;
      is_div_q <= 1'b0;
      nq_q     <= 1'b0;
      nr_q     <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      up_q     <= up_d;
      lw_q     <= lw_d;
      dv_q     <= dv_d;
      is_div_q <= is_div_d;
      nq_q     <= nq_d;
      nr_q     <= nr_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: N, default 32, operand width in bits; SHALL support any even N from 8 to 64.
REQ-002 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; while low, the block is held in its reset state.
REQ-004 Port: start  input  1  request a new operation; sampled on a rising edge.
REQ-005 Port: op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Port: inA  input  N  multiplicand or dividend (rs).
REQ-007 Port: inB  input  N  multiplier or divisor (rt).
REQ-008 Port: hi_write  input  1  MTHI: load write_data into HI.
REQ-009 Port: lo_write  input  1  MTLO: load write_data into LO.
REQ-010 Port: write_data  input  N  data for MTHI and MTLO.
REQ-011 Port: busy  output  1  operation in progress.
REQ-012 Port: done  output  1  one-cycle completion pulse.
REQ-013 Port: div_by_zero  output  1  one-cycle pulse, coincident with done, for a DIV or DIVU with inB=0.
REQ-014 Port: hi  output  N  HI register.
REQ-015 Port: lo  output  N  LO register.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, RUN, FINISH.
REQ-017 busy SHALL be 1 exactly when the state is not IDLE.
REQ-018 In IDLE, start=1 at an edge SHALL latch op, inA and inB, clear the iteration counter, and enter RUN.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 RUN SHALL perform one radix-2 iteration per cycle for N cycles, using shift-add for multiply and restoring shift-subtract for divide, on operand magnitudes.
REQ-021 Signed multiply and divide SHALL take operand magnitudes (two's-complement negate of negative inputs) and apply the sign correction in FINISH.
REQ-022 After the Nth iteration, the FSM SHALL enter FINISH for one cycle; at the FINISH-to-IDLE edge, HI and LO SHALL be loaded and done SHALL pulse for the following cycle.
REQ-023 Latency: for start sampled at edge T0, busy SHALL be 1 for cycles T0+1 through T0+N+1.
REQ-024 For the same start, the new HI and LO values and done=1 SHALL be visible in cycle T0+N+2.
REQ-025 MULT and MULTU SHALL set {HI,LO} to the full 2N-bit product, signed or unsigned respectively.
REQ-026 DIV and DIVU SHALL set LO to the quotient and HI to the remainder.
REQ-027 Signed DIV SHALL truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-028 DIV of -2^(N-1) by -1 SHALL give LO=-2^(N-1) (wrapped) and HI=0, with no flag.
REQ-029 For DIV or DIVU with inB=0 at start, the FSM SHALL go directly to FINISH.
REQ-030 In the divide-by-zero case, done and div_by_zero SHALL pulse in cycle T0+2, and HI and LO SHALL be left unchanged.
REQ-031 hi_write and lo_write SHALL take effect only in IDLE and SHALL be ignored while busy=1.
REQ-032 With both hi_write and lo_write asserted, both registers SHALL load write_data.
REQ-033 hi_write or lo_write asserted with start in IDLE SHALL be applied, and the operation SHALL still be accepted; its result later overwrites HI and LO.
REQ-034 done and div_by_zero SHALL never be asserted for more than one consecutive cycle.
REQ-035 A start accepted in the cycle done is high SHALL be legal; the next operation proceeds back-to-back.

Reset
REQ-036 reset low SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, and iteration counter=0.
REQ-037 reset asserted mid-operation SHALL abort the operation with no partial HI or LO update.
REQ-038 After reset deasserts, the first rising edge SHALL be able to accept start.

Verification (N=32)
REQ-039 MULTU inA=0xFFFFFFFF, inB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; busy high 33 cycles; done in cycle T0+34.
REQ-040 MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-041 DIVU 100 / 0 after MTHI 0x1234 and MTLO 0x5678 -> done and div_by_zero in T0+2; HI=0x1234, LO=0x5678.
REQ-042 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, div_by_zero=0.
REQ-043 A second start and an hi_write while busy -> both ignored; the first operation's result is unaffected.
REQ-044 reset pulsed low at iteration 10 of a MULT -> hi=lo=0 and busy=0 immediately; a new MULT 6 x 7 then gives LO=42 and HI=0.
